sa_local_req: RTL

- Per-input-port local switch-allocation stage of the NoC router; one instance per input port.
- Picks one buffered VC per cycle by round-robin and presents it to the global switch allocators as a registered, stable request (valid, VC id, QoS, target output port).
- Holds the request until the target output port's global allocator grants it, then issues a one-cycle pop pulse to the VC buffer.
- Provides the sa_local_vld/vc_id/qos_value producer side consumed by the global SA stage.

---
 rtl/sa_local_req_if.sv | 30 +++
 rtl/sa_local_req.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sa_local_req_if.sv
// Local switch-allocation bundle: VC-buffer request side, global SA request/grant side, pop return.
// master = the local allocator, slave = the surrounding router (VC buffers + global allocators).
interface sa_local_req_if #(
  parameter int VC_NUM     = 4,
  parameter int OUTPUT_NUM = 4,
  parameter int VC_ID_W    = 3,
  parameter int QOS_W      = 4
);
  logic [VC_NUM-1:0]            vc_req_vld_i;
  logic [VC_NUM*OUTPUT_NUM-1:0] vc_req_outport_oh_i;
  logic [VC_NUM*QOS_W-1:0]      vc_req_qos_i;
  logic [OUTPUT_NUM-1:0]        sa_global_grt_i;
  logic                         sa_local_vld_o;
  logic [VC_ID_W-1:0]           sa_local_vc_id_o;
  logic [QOS_W-1:0]             sa_local_qos_value_o;
  logic [OUTPUT_NUM-1:0]        sa_local_outport_oh_o;
  logic [VC_NUM-1:0]            sa_local_pop_vc_oh_o;

  modport master (
    input  vc_req_vld_i, vc_req_outport_oh_i, vc_req_qos_i, sa_global_grt_i,
    output sa_local_vld_o, sa_local_vc_id_o, sa_local_qos_value_o, sa_local_outport_oh_o,
           sa_local_pop_vc_oh_o
  );

  modport slave (
    output vc_req_vld_i, vc_req_outport_oh_i, vc_req_qos_i, sa_global_grt_i,
    input  sa_local_vld_o, sa_local_vc_id_o, sa_local_qos_value_o, sa_local_outport_oh_o,
           sa_local_pop_vc_oh_o
  );
endinterface

// File: rtl/sa_local_req.sv
// Per-input-port local switch allocator: round-robin VC pick, registered request held until granted.
// Optional QoS aging of the held request is enabled by defining SA_LOCAL_QOS_AGING_EN.
module sa_local_req #(
  parameter int VC_NUM       = 4,
  parameter int OUTPUT_NUM   = 4,
  parameter int VC_ID_W      = 3,
  parameter int QOS_W        = 4,
  parameter int HOLD_TIMEOUT = 16,
  parameter int AGE_PERIOD   = 8
) (
  input logic           clk,
  input logic           rstn,
  sa_local_req_if.master bus
);

  localparam int HCNT_W = $clog2(HOLD_TIMEOUT);

  if (VC_NUM < 1 || VC_NUM > 6 || HOLD_TIMEOUT < 2 || AGE_PERIOD < 1) begin : g_param_err
    $error("sa_local_req: illegal parameter set");
  end

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                state_q, state_d;
  logic [VC_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [VC_ID_W-1:0]    held_q, held_d;
  logic [QOS_W-1:0]      qos_q, qos_d;
  logic [OUTPUT_NUM-1:0] outport_q, outport_d;
  logic [HCNT_W-1:0]     hold_cnt_q, hold_cnt_d;

  logic [VC_NUM-1:0]     held_oh, arb_mask, cand;
  logic [VC_ID_W-1:0]    next_ptr, arb_ptr, win_idx;
  logic [QOS_W-1:0]      win_qos;
  logic [OUTPUT_NUM-1:0] win_outport;
  logic                  win_found, held_vld, granted, timeout, load, stay;

`ifdef SA_LOCAL_QOS_AGING_EN
  localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  logic [AGE_W-1:0] age_cnt_q, age_cnt_d;
`endif

  assign held_oh  = VC_NUM'(1) << held_q;
  assign next_ptr = (held_q == VC_ID_W'(VC_NUM - 1)) ? '0 : held_q + 1'b1;
  assign held_vld = |(bus.vc_req_vld_i & held_oh);
  assign granted  = |(bus.sa_global_grt_i & outport_q);
  assign timeout  = (hold_cnt_q == HCNT_W'(HOLD_TIMEOUT - 1));

  // A release from HOLD re-arbitrates with the outgoing VC excluded, starting just past it.
  always_comb begin
    arb_mask = '0;
    arb_ptr  = rr_ptr_q;
    if (state_q == StHold) begin
      arb_mask = held_oh;
      arb_ptr  = next_ptr;
    end
  end

  assign cand = bus.vc_req_vld_i & ~arb_mask;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < VC_NUM; off++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (!win_found && cand[v] &&
            ((int'(arb_ptr) + off == v) || (int'(arb_ptr) + off == v + VC_NUM))) begin
          win_found = 1'b1;
          win_idx   = VC_ID_W'(v);
        end
      end
    end
  end

  always_comb begin
    win_qos     = '0;
    win_outport = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (win_idx == VC_ID_W'(v)) begin
        win_qos     = bus.vc_req_qos_i[v*QOS_W +: QOS_W];
        win_outport = bus.vc_req_outport_oh_i[v*OUTPUT_NUM +: OUTPUT_NUM];
      end
    end
  end

  // Next-state: flush beats grant beats timeout.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StHold;
          load    = 1'b1;
        end
      end
      StHold: begin
        if (!held_vld) begin
          state_d = StIdle;
        end else if (granted || timeout) begin
          rr_ptr_d = next_ptr;
          if (win_found) load = 1'b1;
          else           state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stay = (state_q == StHold) && (state_d == StHold) && !load;

  always_comb begin
    held_d     = held_q;
    qos_d      = qos_q;
    outport_d  = outport_q;
    hold_cnt_d = hold_cnt_q;
`ifdef SA_LOCAL_QOS_AGING_EN
    age_cnt_d  = age_cnt_q;
`endif
    if (load) begin
      held_d     = win_idx;
      qos_d      = win_qos;
      outport_d  = win_outport;
      hold_cnt_d = '0;
`ifdef SA_LOCAL_QOS_AGING_EN
      age_cnt_d  = '0;
`endif
    end else if (stay) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
`ifdef SA_LOCAL_QOS_AGING_EN
      if (age_cnt_q == AGE_W'(AGE_PERIOD - 1)) begin
        age_cnt_d = '0;
        if (qos_q != '1) qos_d = qos_q + 1'b1;
      end else begin
        age_cnt_d = age_cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      held_q     <= '0;
      qos_q      <= '0;
      outport_q  <= '0;
      hold_cnt_q <= '0;
`ifdef SA_LOCAL_QOS_AGING_EN
      age_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      held_q     <= held_d;
      qos_q      <= qos_d;
      outport_q  <= outport_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef SA_LOCAL_QOS_AGING_EN
      age_cnt_q  <= age_cnt_d;
`endif
    end
  end

  // Request fields come only from registers; pop is the only combinational output.
  always_comb begin
    bus.sa_local_vld_o        = (state_q == StHold);
    bus.sa_local_vc_id_o      = held_q;
    bus.sa_local_qos_value_o  = qos_q;
    bus.sa_local_outport_oh_o = outport_q;
    bus.sa_local_pop_vc_oh_o  = '0;
    if (state_q == StHold && held_vld && granted) bus.sa_local_pop_vc_oh_o = held_oh;
  end

endmodule
